// File: rtl/wand_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wand_arb_pkg
// Brief    : Shared state encodings and width helper for the wired-AND arbiter
// Revision : 1.0 - initial release
// ============================================================================
package wand_arb_pkg;

  // FSM state encodings
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_ARB  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = C_ST_IDLE,
    ST_ARB  = C_ST_ARB,
    ST_DONE = C_ST_DONE
  } state_e;

  // Index width for n items; a single item still needs one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wand_arb_lane.sv
`default_nettype none
// ============================================================================
// Module   : wand_arb_lane
// Brief    : One arbitration channel: ID shift register plus active flag.
//            Drives its current MSB onto the wired-AND bus and withdraws when
//            it drives a recessive 1 while the bus resolves to 0.
// Revision : 1.0 - initial release
// ============================================================================
module wand_arb_lane #(
  parameter int ID_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_req,
  input  logic [ID_W-1:0] i_id,
  input  logic            i_shift,
  input  logic            i_bus,
  output logic            o_drive,
  output logic            o_act_nxt
);

  logic [ID_W-1:0] r_sh;
  logic            r_act;
  logic            w_withdraw;

  // A lane that has withdrawn (or never requested) is recessive on the bus
  assign o_drive    = ~r_act | r_sh[ID_W-1];
  assign w_withdraw = r_act & r_sh[ID_W-1] & ~i_bus;
  // Active flag as it will be after the current bit is resolved
  assign o_act_nxt  = r_act & ~w_withdraw;

  // Latch ID/request on load, otherwise shift out one bit per arbitration cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_act <= 1'b0;
    end else if (i_load) begin
      r_sh  <= i_id;
      r_act <= i_req;
    end else if (i_shift) begin
      r_sh  <= r_sh << 1;
      r_act <= o_act_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wand_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wand_arbiter
// Brief    : N-channel bitwise arbiter on a dominant-0 wired-AND bus. Lowest
//            ID wins after ID_W bit-cycles; ties go to the lowest channel.
// Revision : 1.0 - initial release
// ============================================================================
module wand_arbiter
  import wand_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = 8,
  parameter int CH_W = clog2_min1(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*ID_W-1:0] id,
  output logic                 bus,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH-1:0]      grant,
  output logic [CH_W-1:0]      winner,
  output logic [ID_W-1:0]      win_id,
  output logic                 no_req
);

  localparam int CNT_W = clog2_min1(ID_W);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_acc;
  logic             r_busy;
  logic             r_done;
  logic [N_CH-1:0]  r_grant;
  logic [CH_W-1:0]  r_winner;
  logic [ID_W-1:0]  r_win_id;
  logic             r_no_req;

  logic [N_CH-1:0]  w_drive;
  logic [N_CH-1:0]  w_act_nxt;
  logic             w_bus;
  logic             w_load;
  logic             w_shift;
  logic [CH_W-1:0]  w_idx;
  logic [N_CH-1:0]  w_grant;
  logic [ID_W-1:0]  w_id_final;

  assign w_load  = (r_state == ST_IDLE) && start && (|req);
  assign w_shift = (r_state == ST_ARB);

  // Bus is recessive outside arbitration; inside it is the AND of all lanes
  assign w_bus = (r_state == ST_ARB) ? (&w_drive) : 1'b1;
  assign bus   = w_bus;

  // The resolved bus bits, MSB first, spell out the winning ID
  assign w_id_final = (r_acc << 1) | ID_W'(w_bus);

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
      wand_arb_lane #(
        .ID_W (ID_W)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_req     (req[g]),
        .i_id      (id[g*ID_W +: ID_W]),
        .i_shift   (w_shift),
        .i_bus     (w_bus),
        .o_drive   (w_drive[g]),
        .o_act_nxt (w_act_nxt[g])
      );
    end
  endgenerate

  // Lowest-index survivor wins; handles identical IDs
  always_comb begin
    w_idx   = '0;
    w_grant = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_act_nxt[i]) begin
        w_idx = CH_W'(i);
      end
    end
    if (|w_act_nxt) begin
      w_grant = N_CH'(1) << w_idx;
    end
  end

  // Control FSM, bit counter and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_grant  <= '0;
      r_winner <= '0;
      r_win_id <= '0;
      r_no_req <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_grant  <= '0;
            r_winner <= '0;
            r_win_id <= '0;
            r_acc    <= '0;
            r_no_req <= ~(|req);
            r_busy   <= 1'b1;
            if (|req) begin
              r_state <= ST_ARB;
              r_cnt   <= CNT_W'(ID_W - 1);
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_ARB: begin
          r_acc <= w_id_final;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_grant  <= w_grant;
            r_winner <= w_idx;
            r_win_id <= w_id_final;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign grant  = r_grant;
  assign winner = r_winner;
  assign win_id = r_win_id;
  assign no_req = r_no_req;

endmodule
`default_nettype wire

// File: tb/tb_wand_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wand_arbiter
// Brief    : Directed self-checking bench for wand_arbiter (N_CH=4, ID_W=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_wand_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  req;
  logic [31:0] id;
  logic        bus;
  logic        busy;
  logic        done;
  logic [3:0]  grant;
  logic [1:0]  winner;
  logic [7:0]  win_id;
  logic        no_req;

  int n_vec = 0;
  int n_err = 0;

  wand_arbiter #(
    .N_CH (4),
    .ID_W (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .req    (req),
    .id     (id),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .grant  (grant),
    .winner (winner),
    .win_id (win_id),
    .no_req (no_req)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".bus"},    32'(bus),    32'd1);
    chk({tag, ".busy"},   32'(busy),   32'd0);
    chk({tag, ".done"},   32'(done),   32'd0);
    chk({tag, ".grant"},  32'(grant),  32'd0);
    chk({tag, ".winner"}, 32'(winner), 32'd0);
    chk({tag, ".win_id"}, 32'(win_id), 32'd0);
    chk({tag, ".no_req"}, 32'(no_req), 32'd0);
  endtask

  // One full arbitration; optionally disturb inputs in the third ARB cycle
  task automatic arb_run(input string tag, input logic [3:0] r, input logic [31:0] ids,
                         input logic [7:0] exp_bus, input logic [3:0] exp_grant,
                         input logic [1:0] exp_winner, input logic [7:0] exp_win_id,
                         input bit perturb);
    req   = r;
    id    = ids;
    start = 1'b1;
    step();                              // E0
    start = 1'b0;
    chk({tag, ".busy0"},  32'(busy),  32'd1);
    chk({tag, ".grant0"}, 32'(grant), 32'd0);
    chk({tag, ".bus7"},   32'(bus),   32'(exp_bus[7]));
    for (int b = 6; b >= 0; b--) begin
      step();
      if (perturb && b == 5) begin
        start = 1'b1;
        req   = ~r;
        id    = ~ids;
      end
      if (perturb && b == 4) begin
        start = 1'b0;
      end
      chk($sformatf("%s.bus%0d", tag, b), 32'(bus), 32'(exp_bus[b]));
      chk($sformatf("%s.nodone%0d", tag, b), 32'(done), 32'd0);
    end
    step();                              // E8: result cycle
    chk({tag, ".done"},   32'(done),   32'd1);
    chk({tag, ".busyd"},  32'(busy),   32'd1);
    chk({tag, ".busd"},   32'(bus),    32'd1);
    chk({tag, ".grant"},  32'(grant),  32'(exp_grant));
    chk({tag, ".winner"}, 32'(winner), 32'(exp_winner));
    chk({tag, ".win_id"}, 32'(win_id), 32'(exp_win_id));
    chk({tag, ".no_req"}, 32'(no_req), 32'd0);
    step();
    chk({tag, ".done_off"}, 32'(done),  32'd0);
    chk({tag, ".idle"},     32'(busy),  32'd0);
    chk({tag, ".hold"},     32'(grant), 32'(exp_grant));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    req   = 4'b0000;
    id    = 32'h0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // Scenario 1: ch2 (0x3A) wins
    arb_run("s1", 4'b1111, {8'hFF, 8'h3A, 8'h3C, 8'hA5}, 8'b0011_1010,
            4'b0100, 2'd2, 8'h3A, 1'b0);

    // Scenario 2: identical IDs on ch1/ch3, lowest index wins
    arb_run("s2", 4'b1010, {8'h10, 8'h00, 8'h10, 8'h00}, 8'b0001_0000,
            4'b0010, 2'd1, 8'h10, 1'b0);

    // Scenario 3: empty request
    req   = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s3.done",   32'(done),   32'd1);
    chk("s3.no_req", 32'(no_req), 32'd1);
    chk("s3.grant",  32'(grant),  32'd0);
    chk("s3.bus",    32'(bus),    32'd1);
    chk("s3.busy",   32'(busy),   32'd1);
    step();
    chk("s3.done_off", 32'(done),   32'd0);
    chk("s3.hold",     32'(no_req), 32'd1);
    chk("s3.bus_idle", 32'(bus),    32'd1);

    // Scenario 4: restart and input changes during ARB are ignored
    arb_run("s4", 4'b1111, {8'hFF, 8'h3A, 8'h3C, 8'hA5}, 8'b0011_1010,
            4'b0100, 2'd2, 8'h3A, 1'b1);

    // Scenario 5: reset in the 4th ARB cycle
    req   = 4'b1111;
    id    = {8'hFF, 8'h3A, 8'h3C, 8'hA5};
    start = 1'b1;
    step();                              // E0
    start = 1'b0;
    step();
    step();
    step();                              // now in 4th ARB cycle
    chk("s5.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk_reset("s5.rst");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("s5.quiet%0d", c), 32'(done), 32'd0);
    end
    arb_run("s5.rerun", 4'b1111, {8'hFF, 8'h3A, 8'h3C, 8'hA5}, 8'b0011_1010,
            4'b0100, 2'd2, 8'h3A, 1'b0);

    // Scenario 6: single requester with all-ones ID
    arb_run("s6", 4'b1000, {8'hFF, 8'h00, 8'h00, 8'h00}, 8'b1111_1111,
            4'b1000, 2'd3, 8'hFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so a stuck run still ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/wand_arbiter.md
# wand_arbiter

Parametrised N-channel bitwise arbiter built on a wired-AND (dominant-0) bus. On `start`, each requesting channel shifts its ID onto the bus MSB-first. A channel that drives 1 while the bus reads 0 withdraws, so the lowest ID wins in exactly `ID_W` bit-cycles. It generalises the combinational 4-input wired-AND net into a clocked, multi-cycle arbitration block that shared-bus masters use for access control.

## Interface
- `N_CH`, 4, number of requesting channels (≥1)
- `ID_W`, 8, ID width in bits (≥1)
- `CH_W`, derived: `$clog2(N_CH)` when `N_CH`>1, otherwise 1
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begins arbitration; sampled only in IDLE
- `req`  in  N_CH  per-channel request; latched on accepted `start`
- `id`  in  N_CH*ID_W  flattened IDs; channel k uses bits [k*ID_W +: ID_W]; latched on accepted `start`
- `bus`  out  1  resolved wired-AND bit for the current arbitration cycle
- `busy`  out  1  high in ARB and DONE
- `done`  out  1  one-cycle pulse; result outputs are valid while it is high
- `grant`  out  N_CH  one-hot winner mask
- `winner`  out  CH_W  winner index
- `win_id`  out  ID_W  winning ID
- `no_req`  out  1  set when `start` was accepted with `req`==0

## Operation
- States: IDLE, ARB, DONE.
- **IDLE → ARB** on `start`=1 with `req`≠0:
  - latch `req` into the active mask and `id` into per-channel shift registers
  - set bit counter = `ID_W`-1
- **IDLE → DONE** on `start`=1 with `req`==0:
  - `grant`=0, `winner`=0, `win_id`=0, `no_req`=1
- **ARB:**
  - `bus` = AND over active channels of each channel's current MSB; inactive channels contribute 1.
  - Each edge: a channel whose MSB=1 while `bus`=0 clears its active bit. All shift registers shift left. Counter decrements.
  - After the bit at counter 0 is processed → DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, then → IDLE.
  - If more than one channel is still active (identical IDs), the lowest index wins; `grant` has exactly one bit set.
- `grant`, `winner`, `win_id` and `no_req` hold their values until the next accepted `start`, which clears them.
- `start` is ignored in ARB and DONE. Changes to `req` and `id` after latching have no effect.
- `bus`=1 (recessive) in IDLE and DONE.

## Timing
- Reset values: state IDLE, `bus`=1, `busy`=0, `done`=0, `grant`=0, `winner`=0, `win_id`=0, `no_req`=0.
- Normal arbitration (`start` accepted at edge E0):
  - `bus` carries ID bit `ID_W`-1 in the cycle after E0 and bit 0 in the cycle after E(`ID_W`-1).
  - `done` is high in the cycle after E(`ID_W`).
  - `busy` is high from after E0 through the DONE cycle.
- Empty request: `done` is high in the cycle after E0.
- Throughput: one arbitration per `ID_W`+2 cycles, since `start` is accepted only in IDLE.
- `rst` has priority over every event, including mid-ARB and during DONE. The next cycle shows reset values, with no `done` pulse.
- Fully synchronous; no combinational path from inputs to outputs except through state. `bus` is combinational from registers only.

## Structure
- Shared package `wand_arb_pkg`:
  - state encodings IDLE/ARB/DONE as localparams
  - `CH_W` derivation function
- Sub-module `wand_arb_lane`, one per channel via generate. It holds the ID shift register and active flag, outputs its current MSB, and takes `bus` back to decide withdrawal.
- Top level (`wand_arbiter`) contains:
  - the wired-AND resolution
  - the FSM and bit counter
  - the lowest-index priority encoder for `grant`/`winner`

## Test plan
All scenarios use `N_CH`=4, `ID_W`=8.
1. IDs ch0=0xA5, ch1=0x3C, ch2=0x3A, ch3=0xFF; `req`=1111; `start` pulse → `bus` sequence 0,0,1,1,1,0,1,0; `done` in the cycle after E8; `grant`=0100, `winner`=2, `win_id`=0x3A.
2. ch1=ch3=0x10, `req`=1010 → `grant`=0010, `winner`=1, `win_id`=0x10.
3. `start` with `req`=0000 → `done` in the cycle after E0, `no_req`=1, `grant`=0000; `bus` stays 1.
4. After scenario 1 starts, re-pulse `start` and change `req`/`id` at cycle 3 → ignored; result is identical to scenario 1.
5. `rst`=1 during the 4th ARB cycle → next cycle shows all reset values, no `done` pulse; a subsequent scenario-1 run passes.
6. Only ch3 requests, ID 0xFF → `bus`=1 for all 8 cycles; `grant`=1000, `winner`=3, `win_id`=0xFF.
